// File: rtl/dec_bin_pkg.sv
// Shared types and constants for the 3-digit BCD to 8-bit binary converter.
// Shift register layout, MSB to LSB: {hun[1:0], ten[3:0], one[3:0], bin[7:0]}.
package dec_bin_pkg;

    localparam int BIN_W   = 8;
    localparam int BCD_W   = 10;
    localparam int N_SHIFT = 8;
    localparam int CNT_W   = 3;
    localparam int SR_W    = BCD_W + BIN_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SHIFT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // True when any digit lies outside its legal BCD range.
    function automatic logic bcd_invalid(input logic [1:0] h,
                                         input logic [3:0] t,
                                         input logic [3:0] o);
        return (h == 2'd3) || (t > 4'd9) || (o > 4'd9);
    endfunction

endpackage

// File: rtl/dec_bin_bcd_digit_adj.sv
// Reverse double-dabble digit correction: a nibble that received a shifted-in
// MSB (value >= 8) is pulled back into BCD range by subtracting 3.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/dec_bin.sv
// Three-digit BCD to 8-bit binary converter using reverse double-dabble:
// one load cycle, eight shift/correct cycles, one result cycle.
module dec_bin
    import dec_bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       hun,
    input  logic [3:0]       ten,
    input  logic [3:0]       one,
    output logic [BIN_W-1:0] bin,
    output logic             err,
    output logic             busy,
    output logic             done
);

    state_t            state_reg;
    logic [SR_W-1:0]   sr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              bad_reg;

    logic [SR_W-1:0]   sr_shift;
    logic [SR_W-1:0]   sr_next;
    logic [1:0][3:0]   adj;

    assign sr_shift = {1'b0, sr_reg[SR_W-1:1]};

    // Index 0 corrects the ones nibble, index 1 the tens nibble.
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr_shift[BIN_W + 4*gi +: 4]),
            .dout (adj[gi])
        );
    end

    assign sr_next = {sr_shift[SR_W-1 -: 2], adj[1], adj[0], sr_shift[BIN_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            bad_reg   <= 1'b0;
            bin       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sr_reg    <= {hun, ten, one, {BIN_W{1'b0}}};
                        cnt_reg   <= '0;
                        bad_reg   <= bcd_invalid(hun, ten, one);
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_reg  <= sr_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    // Residue left in the BCD field means the value exceeded 255.
                    if (bad_reg || (|sr_reg[SR_W-1:BIN_W])) begin
                        err <= 1'b1;
                        bin <= '0;
                    end else begin
                        err <= 1'b0;
                        bin <= sr_reg[BIN_W-1:0];
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
